// File: rtl/cavlc_pkg.sv
// Shared constants and FSM state encoding for the CAVLC statistics sequencer.
package cavlc_pkg;

  localparam int unsigned COEF_W   = 9;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned NUM_COEF = 16;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRead,
    StDrain,
    StPresent
  } state_e;

endpackage

// File: rtl/cavlc_valid_delay.sv
// Shift pipe that delays {en, addr} by the BRAM read latency so the statistics buffer
// sees its qualifier in the same cycle as the read data.
module cavlc_valid_delay #(
  parameter int unsigned Lat   = 1,
  parameter int unsigned Width = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o
);

  logic [Width-1:0] pipe_q [Lat];
  logic [Width-1:0] pipe_d [Lat];

  always_comb begin
    pipe_d[0] = data_i;
    for (int unsigned i = 1; i < Lat; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < Lat; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign data_o = pipe_q[Lat-1];

endmodule

// File: rtl/cavlc_stats_ctrl.sv
// Sequencer for the CAVLC statistics stage of one 4x4 block: clear, reverse-scan read,
// drain the BRAM latency, then hand the latched statistics to the VLC encoder.
module cavlc_stats_ctrl
  import cavlc_pkg::*;
#(
  parameter int unsigned BRAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              stat_clr,
  output logic              counters_en,
  output logic [ADDR_W-1:0] stat_addr,
  input  logic [4:0]        nzq_in,
  input  logic [3:0]        tzeros_in,
  input  logic [1:0]        t1_num_in,
  input  logic [2:0]        t1_sign_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        total_coeff,
  output logic [3:0]        total_zeros,
  output logic [1:0]        trail_ones,
  output logic [2:0]        trail_sign,
  output logic              zero_blk
);

  localparam int unsigned DrainW = 3;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic              busy_q, busy_d;
  logic              bram_en_q, bram_en_d;
  logic              stat_clr_q, stat_clr_d;
  logic              out_valid_q, out_valid_d;
  logic [4:0]        total_coeff_q, total_coeff_d;
  logic [3:0]        total_zeros_q, total_zeros_d;
  logic [1:0]        trail_ones_q, trail_ones_d;
  logic [2:0]        trail_sign_q, trail_sign_d;
  logic              zero_blk_q, zero_blk_d;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    drain_d       = drain_q;
    bram_en_d     = 1'b0;
    stat_clr_d    = 1'b0;
    out_valid_d   = out_valid_q;
    total_coeff_d = total_coeff_q;
    total_zeros_d = total_zeros_q;
    trail_ones_d  = trail_ones_q;
    trail_sign_d  = trail_sign_q;
    zero_blk_d    = zero_blk_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StClear;
          stat_clr_d = 1'b1;
        end
      end
      StClear: begin
        state_d   = StRead;
        bram_en_d = 1'b1;
        addr_d    = ADDR_W'(NUM_COEF - 1);
      end
      StRead: begin
        // Stop at address 0 rather than wrapping back to 15.
        if (addr_q == '0) begin
          state_d = StDrain;
          drain_d = DrainW'(BRAM_LAT);
        end else begin
          bram_en_d = 1'b1;
          addr_d    = addr_q - 1'b1;
        end
      end
      StDrain: begin
        if (drain_q == '0) begin
          state_d       = StPresent;
          out_valid_d   = 1'b1;
          total_coeff_d = nzq_in;
          total_zeros_d = tzeros_in;
          trail_ones_d  = t1_num_in;
          trail_sign_d  = t1_sign_in;
          zero_blk_d    = (nzq_in == '0);
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      StPresent: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (start) begin
            state_d    = StClear;
            stat_clr_d = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      drain_q       <= '0;
      busy_q        <= 1'b0;
      bram_en_q     <= 1'b0;
      stat_clr_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      total_coeff_q <= '0;
      total_zeros_q <= '0;
      trail_ones_q  <= '0;
      trail_sign_q  <= '0;
      zero_blk_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      drain_q       <= drain_d;
      busy_q        <= busy_d;
      bram_en_q     <= bram_en_d;
      stat_clr_q    <= stat_clr_d;
      out_valid_q   <= out_valid_d;
      total_coeff_q <= total_coeff_d;
      total_zeros_q <= total_zeros_d;
      trail_ones_q  <= trail_ones_d;
      trail_sign_q  <= trail_sign_d;
      zero_blk_q    <= zero_blk_d;
    end
  end

  cavlc_valid_delay #(
    .Lat   (BRAM_LAT),
    .Width (ADDR_W + 1)
  ) u_valid_delay (
    .clk    (clk),
    .rst    (rst),
    .data_i ({bram_en_q, addr_q}),
    .data_o ({counters_en, stat_addr})
  );

  assign busy        = busy_q;
  assign bram_en     = bram_en_q;
  assign bram_addr   = addr_q;
  assign stat_clr    = stat_clr_q;
  assign out_valid   = out_valid_q;
  assign total_coeff = total_coeff_q;
  assign total_zeros = total_zeros_q;
  assign trail_ones  = trail_ones_q;
  assign trail_sign  = trail_sign_q;
  assign zero_blk    = zero_blk_q;

endmodule

// File: tb/tb_cavlc_stats_ctrl.sv
// Bench for cavlc_stats_ctrl: BRAM and statistics-buffer models feed the DUT, a scoreboard
// holds the expected statistics and out_valid cycle for every accepted start.
module tb_cavlc_stats_ctrl;
  import cavlc_pkg::*;

  typedef struct packed {
    logic [4:0] nzq;
    logic [3:0] tz;
    logic [1:0] t1;
    logic [2:0] sign;
  } stats_t;

  typedef struct packed {
    stats_t s;
    logic   seen;
    logic   open;
  } buf_t;

  typedef struct packed {
    stats_t      s;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, out_ready, start3, out_ready3;
  logic       busy, bram_en, stat_clr, counters_en, out_valid, zero_blk;
  logic [3:0] bram_addr, stat_addr, total_zeros;
  logic [4:0] total_coeff;
  logic [1:0] trail_ones;
  logic [2:0] trail_sign;
  logic       busy3, bram_en3, stat_clr3, counters_en3, out_valid3, zero_blk3;
  logic [3:0] bram_addr3, stat_addr3, total_zeros3;
  logic [4:0] total_coeff3;
  logic [1:0] trail_ones3;
  logic [2:0] trail_sign3;

  logic [8:0]  mem [16];
  buf_t        buf1, buf3;
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  exp_t        exp_q [$];

  cavlc_stats_ctrl #(.BRAM_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .bram_en(bram_en),
    .bram_addr(bram_addr), .stat_clr(stat_clr), .counters_en(counters_en),
    .stat_addr(stat_addr), .nzq_in(buf1.s.nzq), .tzeros_in(buf1.s.tz),
    .t1_num_in(buf1.s.t1), .t1_sign_in(buf1.s.sign), .out_valid(out_valid),
    .out_ready(out_ready), .total_coeff(total_coeff), .total_zeros(total_zeros),
    .trail_ones(trail_ones), .trail_sign(trail_sign), .zero_blk(zero_blk)
  );

  cavlc_stats_ctrl #(.BRAM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .busy(busy3), .bram_en(bram_en3),
    .bram_addr(bram_addr3), .stat_clr(stat_clr3), .counters_en(counters_en3),
    .stat_addr(stat_addr3), .nzq_in(buf3.s.nzq), .tzeros_in(buf3.s.tz),
    .t1_num_in(buf3.s.t1), .t1_sign_in(buf3.s.sign), .out_valid(out_valid3),
    .out_ready(out_ready3), .total_coeff(total_coeff3), .total_zeros(total_zeros3),
    .trail_ones(trail_ones3), .trail_sign(trail_sign3), .zero_blk(zero_blk3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Direct reference; trail_sign bit k is 1 when the k-th trailing one (highest frequency
  // first) is positive.
  function automatic stats_t ref_stats();
    stats_t s;
    int     hi = -1;
    int     k = 0;
    bit     open = 1'b1;
    s = '0;
    for (int i = 0; i < 16; i++) begin
      if (mem[i][7:0] != 0) begin
        s.nzq = s.nzq + 5'd1;
        hi = i;
      end
    end
    for (int i = 0; i < hi; i++) if (mem[i][7:0] == 0) s.tz = s.tz + 4'd1;
    for (int i = 15; i >= 0; i--) begin
      if (mem[i][7:0] != 0 && open) begin
        if (mem[i][7:0] == 1 && k < 3) begin
          s.sign[k] = !mem[i][8];
          k++;
        end else begin
          open = 1'b0;
        end
      end
    end
    s.t1 = 2'(k);
    return s;
  endfunction

  // Incremental statistics buffer, fed one coefficient per counters_en.
  function automatic buf_t buf_step(input buf_t b, input logic [8:0] c);
    if (c[7:0] == 0) begin
      if (b.seen) b.s.tz = b.s.tz + 4'd1;
    end else begin
      b.s.nzq = b.s.nzq + 5'd1;
      if (!b.seen) begin
        b.seen = 1'b1;
        b.open = 1'b1;
      end
      if (b.open && c[7:0] == 1 && b.s.t1 < 3) begin
        b.s.sign[b.s.t1] = ~c[8];
        b.s.t1 = b.s.t1 + 2'd1;
      end else begin
        b.open = 1'b0;
      end
    end
    return b;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst || stat_clr) buf1 <= '0;
    else if (counters_en) buf1 <= buf_step(buf1, mem[stat_addr]);
  end

  always @(posedge clk) begin
    if (rst || stat_clr3) buf3 <= '0;
    else if (counters_en3) buf3 <= buf_step(buf3, mem[stat_addr3]);
  end

  // Monitor / scoreboard for the BRAM_LAT=1 instance.
  initial begin
    int     exp_addr = -1;
    int     exp_sa = -1;
    int     n_cen = 0;
    bit     prev_cen = 1'b0;
    bit     prev_valid = 1'b0;
    stats_t cur = '0;
    exp_t   e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        exp_addr = -1;
        exp_sa = -1;
        n_cen = 0;
        prev_cen = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (stat_clr) begin
          check_eq("clr_excl_cen", 32'(counters_en), 0);
          exp_addr = 15;
          exp_sa = 15;
          n_cen = 0;
        end
        if (bram_en) begin
          check_eq("bram_addr", 32'(bram_addr), exp_addr);
          exp_addr--;
        end
        if (counters_en) begin
          check_eq("stat_addr", 32'(stat_addr), exp_sa);
          exp_sa--;
          n_cen++;
        end
        if (prev_cen && !counters_en) check_eq("cen_run_len", n_cen, 16);
        if (out_valid && !prev_valid) begin
          check_eq("sb_pending", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            cur = e.s;
            check_eq("valid_cycle", cyc, e.cyc);
          end
        end
        if (out_valid) begin
          check_eq("stats", {total_coeff, total_zeros, trail_ones, trail_sign}, cur);
          check_eq("zero_blk", 32'(zero_blk), 32'(cur.nzq == 0));
          check_eq("present_busy", {busy, bram_en}, 2'b10);
        end
        prev_cen = counters_en;
        prev_valid = out_valid;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start pulse that the DUT will accept; queues the expected result.
  task automatic pulse_start(output int unsigned c);
    tick();
    start = 1'b1;
    c = cyc;
    exp_q.push_back('{s: ref_stats(), cyc: cyc + 20});
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int max);
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check_eq("valid_seen", 32'(out_valid), 1);
  endtask

  task automatic load_t1();
    for (int i = 0; i < 16; i++) mem[i] = 9'h000;
    mem[1] = 9'h003;
    mem[2] = 9'h101;
    mem[5] = 9'h101;
    mem[6] = 9'h001;
    mem[7] = 9'h001;
  endtask

  task automatic load_rand();
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(2) == 0) mem[i] = {1'($urandom_range(1)), 8'($urandom_range(3, 1))};
      else mem[i] = 9'h000;
    end
  endtask

  function automatic logic [27:0] all_outs();
    return {busy, bram_en, bram_addr, stat_clr, counters_en, stat_addr, out_valid,
            total_coeff, total_zeros, trail_ones, trail_sign, zero_blk};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned c;
    int first, last, cnt, vfirst, last_sa;
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    start3 = 1'b0;
    out_ready3 = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 9'h000;
    repeat (3) tick();
    @(negedge clk);
    check_eq("reset_outs", all_outs(), 0);
    check_eq("reset_outs3", {busy3, bram_en3, stat_clr3, counters_en3, out_valid3}, 0);
    tick();
    rst = 1'b0;

    // Test 1: reference block.
    load_t1();
    pulse_start(c);
    wait_valid(40);
    check_eq("t1_spec_stats", {total_coeff, total_zeros, trail_ones, trail_sign},
             {5'd5, 4'd3, 2'd3, 3'b011});
    check_eq("t1_zero_blk", 32'(zero_blk), 0);
    tick();
    @(negedge clk);
    check_eq("t1_valid_drop", {out_valid, busy}, 2'b00);

    // Test 2: all-zero block.
    for (int i = 0; i < 16; i++) mem[i] = 9'h000;
    pulse_start(c);
    wait_valid(40);
    check_eq("t2_spec", {total_coeff, trail_ones, zero_blk}, {5'd0, 2'd0, 1'b1});
    tick();

    // Test 3: encoder stalls; start pulses in PRESENT are ignored.
    out_ready = 1'b0;
    mem[0] = 9'h002; mem[2] = 9'h101; mem[4] = 9'h001; mem[9] = 9'h103; mem[10] = 9'h001;
    pulse_start(c);
    wait_valid(40);
    for (int k = 0; k < 10; k++) begin
      tick();
      start = k[0];
      @(negedge clk);
      check_eq("t3_hold", {busy, bram_en, stat_clr, out_valid}, 4'b1001);
    end
    tick();
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    check_eq("t3_release", {out_valid, busy}, 2'b00);

    // Test 4: accept and restart in the same PRESENT cycle.
    out_ready = 1'b0;
    load_rand();
    pulse_start(c);
    wait_valid(40);
    tick();
    load_rand();
    out_ready = 1'b1;
    start = 1'b1;
    exp_q.push_back('{s: ref_stats(), cyc: cyc + 20});
    tick();
    start = 1'b0;
    @(negedge clk);
    check_eq("t4_clr", {stat_clr, out_valid}, 2'b10);
    wait_valid(40);
    tick();

    // Test 5: reset in the middle of READ.
    load_rand();
    pulse_start(c);
    while (cyc != c + 10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("t5_outs_cleared", all_outs(), 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_eq("t5_no_cen", {counters_en, out_valid}, 2'b00);
    end
    load_rand();
    pulse_start(c);
    wait_valid(40);
    tick();

    // Test 6: BRAM_LAT=3 instance with the reference block.
    load_t1();
    tick();
    start3 = 1'b1;
    c = cyc;
    tick();
    start3 = 1'b0;
    first = -1; last = -1; cnt = 0; vfirst = -1; last_sa = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (counters_en3) begin
        if (first < 0) first = int'(cyc - c);
        last = int'(cyc - c);
        last_sa = int'(stat_addr3);
        cnt++;
      end
      if (stat_clr3) check_eq("t6_clr_excl_cen", 32'(counters_en3), 0);
      if (out_valid3 && vfirst < 0) begin
        vfirst = int'(cyc - c);
        check_eq("t6_stats", {total_coeff3, total_zeros3, trail_ones3, trail_sign3},
                 {5'd5, 4'd3, 2'd3, 3'b011});
        check_eq("t6_ref", {total_coeff3, total_zeros3, trail_ones3, trail_sign3},
                 ref_stats());
      end
    end
    check_eq("t6_cen_first", first, 5);
    check_eq("t6_cen_last", last, 20);
    check_eq("t6_cen_count", cnt, 16);
    check_eq("t6_last_addr", last_sa, 0);
    check_eq("t6_valid_cycle", vfirst, 22);
    check_eq("t6_idle", 32'(busy3), 0);

    repeat (3) tick();
    check_eq("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
